// File: rtl/vga_timing_pkg.sv
// Shared VGA mode tables and timing helpers for the pipelined timing generator.
// A mode lists visible area, front porch, sync width and back porch for both axes.
package vga_timing_pkg;

  typedef struct packed {
    int h_visible;
    int h_front_porch;
    int h_sync_width;
    int h_back_porch;
    int v_visible;
    int v_front_porch;
    int v_sync_width;
    int v_back_porch;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_mode_t SVGA_800x600_60 = '{800, 40, 128, 88, 600, 1, 4, 23};

  function automatic int timing_total(input int visible, input int front_porch,
                                      input int sync_width, input int back_porch);
    return visible + front_porch + sync_width + back_porch;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with synchronous reset to RESET_VALUE.
// q shows the value presented on d exactly DEPTH cycles earlier.
module vga_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_pipelined.sv
// Parametrised VGA timing generator that requests pixels PIXEL_LATENCY cycles ahead
// of the raster and realigns syncs/blanking with the returned RGB.
module vga_timing_pipelined
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE_AREA    = VGA_640x480_60.h_visible,
  parameter int   H_FRONT_PORCH     = VGA_640x480_60.h_front_porch,
  parameter int   H_SYNC_WIDTH      = VGA_640x480_60.h_sync_width,
  parameter int   H_BACK_PORCH      = VGA_640x480_60.h_back_porch,
  parameter int   V_VISIBLE_AREA    = VGA_640x480_60.v_visible,
  parameter int   V_FRONT_PORCH     = VGA_640x480_60.v_front_porch,
  parameter int   V_SYNC_WIDTH      = VGA_640x480_60.v_sync_width,
  parameter int   V_BACK_PORCH      = VGA_640x480_60.v_back_porch,
  parameter logic H_ACTIVE_POLARITY = 1'b0,
  parameter logic V_ACTIVE_POLARITY = 1'b0,
  parameter int   COLOR_BITS        = 4,
  parameter int   PIXEL_LATENCY     = 2,
  parameter int   FRAME_COUNT_BITS  = 16,
  localparam int  H_TOTAL = timing_total(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH),
  localparam int  V_TOTAL = timing_total(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH),
  localparam int  H_BITS  = $clog2(H_TOTAL),
  localparam int  V_BITS  = $clog2(V_TOTAL)
) (
  input  logic                        clk_pixel,
  input  logic                        in_reset,
  input  logic [COLOR_BITS-1:0]       in_vga_r,
  input  logic [COLOR_BITS-1:0]       in_vga_g,
  input  logic [COLOR_BITS-1:0]       in_vga_b,
  output logic                        out_req_valid,
  output logic [H_BITS-1:0]           out_req_x,
  output logic [V_BITS-1:0]           out_req_y,
  output logic                        out_line_start,
  output logic                        out_frame_start,
  output logic [FRAME_COUNT_BITS-1:0] out_frame_count,
  output logic [COLOR_BITS-1:0]       out_vga_r,
  output logic [COLOR_BITS-1:0]       out_vga_g,
  output logic [COLOR_BITS-1:0]       out_vga_b,
  output logic                        out_vga_horizontal_sync,
  output logic                        out_vga_vertical_sync,
  output logic                        out_visible_area
);

  localparam int HS_START = H_VISIBLE_AREA + H_FRONT_PORCH;
  localparam int HS_END   = HS_START + H_SYNC_WIDTH;
  localparam int VS_START = V_VISIBLE_AREA + V_FRONT_PORCH;
  localparam int VS_END   = VS_START + V_SYNC_WIDTH;

  if (PIXEL_LATENCY < 1) begin : g_bad_latency
    $error("vga_timing_pipelined: PIXEL_LATENCY must be at least 1");
  end
  if (H_FRONT_PORCH < 1 || H_SYNC_WIDTH < 1 || H_BACK_PORCH < 1 ||
      V_FRONT_PORCH < 1 || V_SYNC_WIDTH < 1 || V_BACK_PORCH < 1) begin : g_bad_porch
    $error("vga_timing_pipelined: porch and sync widths must be non-zero");
  end
  if (FRAME_COUNT_BITS < 1) begin : g_bad_frame_bits
    $error("vga_timing_pipelined: FRAME_COUNT_BITS must be at least 1");
  end

  logic [H_BITS-1:0]           x;
  logic [V_BITS-1:0]           y;
  logic [FRAME_COUNT_BITS-1:0] frame_count;
  logic                        x_wrap;
  logic                        y_wrap;

  assign x_wrap = (x == H_BITS'(H_TOTAL - 1));
  assign y_wrap = (y == V_BITS'(V_TOTAL - 1));

  always_ff @(posedge clk_pixel) begin
    if (in_reset) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
    end else begin
      x <= x_wrap ? '0 : x + H_BITS'(1);
      if (x_wrap) begin
        if (y_wrap) begin
          y           <= '0;
          frame_count <= frame_count + FRAME_COUNT_BITS'(1);
        end else begin
          y <= y + V_BITS'(1);
        end
      end
    end
  end

  // Request-stage decode; syncs are kept active-high internally until the output register.
  logic hs_raw;
  logic vs_raw;

  assign out_req_x       = x;
  assign out_req_y       = y;
  assign out_frame_count = frame_count;
  assign out_req_valid   = (x < H_BITS'(H_VISIBLE_AREA)) && (y < V_BITS'(V_VISIBLE_AREA));
  assign out_line_start  = (x == '0);
  assign out_frame_start = (x == '0) && (y == '0);
  assign hs_raw          = (x >= H_BITS'(HS_START)) && (x < H_BITS'(HS_END));
  assign vs_raw          = (y >= V_BITS'(VS_START)) && (y < V_BITS'(VS_END));

  logic [2:0] ctrl_tap;
  logic       tap_valid;
  logic       tap_hs;
  logic       tap_vs;

  vga_delay_line #(
    .WIDTH       (3),
    .DEPTH       (PIXEL_LATENCY),
    .RESET_VALUE (3'b000)
  ) u_ctrl_delay (
    .clk_pixel (clk_pixel),
    .reset     (in_reset),
    .d         ({out_req_valid, hs_raw, vs_raw}),
    .q         (ctrl_tap)
  );

  assign {tap_valid, tap_hs, tap_vs} = ctrl_tap;

  // The pixel source answer is only trusted at the latency tap and only when visible.
  always_ff @(posedge clk_pixel) begin
    if (in_reset) begin
      out_vga_r               <= '0;
      out_vga_g               <= '0;
      out_vga_b               <= '0;
      out_visible_area        <= 1'b0;
      out_vga_horizontal_sync <= ~H_ACTIVE_POLARITY;
      out_vga_vertical_sync   <= ~V_ACTIVE_POLARITY;
    end else begin
      out_vga_r               <= tap_valid ? in_vga_r : '0;
      out_vga_g               <= tap_valid ? in_vga_g : '0;
      out_vga_b               <= tap_valid ? in_vga_b : '0;
      out_visible_area        <= tap_valid;
      out_vga_horizontal_sync <= tap_hs ? H_ACTIVE_POLARITY : ~H_ACTIVE_POLARITY;
      out_vga_vertical_sync   <= tap_vs ? V_ACTIVE_POLARITY : ~V_ACTIVE_POLARITY;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipelined.sv
// Self-checking bench: a small 14x7 raster instance checked cycle by cycle against a
// raster-arithmetic model, plus a default 640x480 instance checked over a few lines.
module tb_vga_timing_pipelined;

  localparam int HV = 8, HFP = 2, HSW = 2, HBP = 2, HT = HV + HFP + HSW + HBP;
  localparam int VV = 4, VFP = 1, VSW = 1, VBP = 1, VT = VV + VFP + VSW + VBP;
  localparam int LAT = 2;
  localparam int FRAME = HT * VT;
  localparam int HIST = 2048;

  typedef struct packed {
    logic       valid;
    logic [3:0] x;
    logic [2:0] y;
    logic       line_start;
    logic       frame_start;
    logic [1:0] frame_count;
  } req_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vis;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_reset = 1'b1;
  logic [3:0] s_r = '0, s_g = '0, s_b = '0;
  logic       s_req_valid, s_line_start, s_frame_start;
  logic [3:0] s_req_x;
  logic [2:0] s_req_y;
  logic [1:0] s_frame_count;
  logic [3:0] s_vga_r, s_vga_g, s_vga_b;
  logic       s_hs, s_vs, s_vis;

  logic        d_reset = 1'b1;
  logic [3:0]  d_r = '0, d_g = '0, d_b = '0;
  logic        d_req_valid, d_line_start, d_frame_start;
  logic [9:0]  d_req_x, d_req_y;
  logic [15:0] d_frame_count;
  logic [3:0]  d_vga_r, d_vga_g, d_vga_b;
  logic        d_hs, d_vs, d_vis;

  vga_timing_pipelined #(
    .H_VISIBLE_AREA (HV), .H_FRONT_PORCH (HFP), .H_SYNC_WIDTH (HSW), .H_BACK_PORCH (HBP),
    .V_VISIBLE_AREA (VV), .V_FRONT_PORCH (VFP), .V_SYNC_WIDTH (VSW), .V_BACK_PORCH (VBP),
    .H_ACTIVE_POLARITY (1'b0), .V_ACTIVE_POLARITY (1'b0),
    .COLOR_BITS (4), .PIXEL_LATENCY (LAT), .FRAME_COUNT_BITS (2)
  ) dut_small (
    .clk_pixel (clk), .in_reset (s_reset),
    .in_vga_r (s_r), .in_vga_g (s_g), .in_vga_b (s_b),
    .out_req_valid (s_req_valid), .out_req_x (s_req_x), .out_req_y (s_req_y),
    .out_line_start (s_line_start), .out_frame_start (s_frame_start),
    .out_frame_count (s_frame_count),
    .out_vga_r (s_vga_r), .out_vga_g (s_vga_g), .out_vga_b (s_vga_b),
    .out_vga_horizontal_sync (s_hs), .out_vga_vertical_sync (s_vs),
    .out_visible_area (s_vis)
  );

  vga_timing_pipelined dut_default (
    .clk_pixel (clk), .in_reset (d_reset),
    .in_vga_r (d_r), .in_vga_g (d_g), .in_vga_b (d_b),
    .out_req_valid (d_req_valid), .out_req_x (d_req_x), .out_req_y (d_req_y),
    .out_line_start (d_line_start), .out_frame_start (d_frame_start),
    .out_frame_count (d_frame_count),
    .out_vga_r (d_vga_r), .out_vga_g (d_vga_g), .out_vga_b (d_vga_b),
    .out_vga_horizontal_sync (d_hs), .out_vga_vertical_sync (d_vs),
    .out_visible_area (d_vis)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  int input_mode = 0;
  logic [11:0] hist [HIST];

  // Reference: cycle n after release requests raster position n, shown LAT+1 cycles later.
  function automatic req_t model_req(input int cyc);
    req_t e;
    int px, py;
    px = cyc % HT;
    py = (cyc / HT) % VT;
    e.valid       = (px < HV) && (py < VV);
    e.x           = 4'(px);
    e.y           = 3'(py);
    e.line_start  = (px == 0);
    e.frame_start = (px == 0) && (py == 0);
    e.frame_count = 2'((cyc / FRAME) % 4);
    return e;
  endfunction

  function automatic out_t model_out(input int cyc);
    out_t e;
    int m, px, py;
    e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, vis: 1'b0};
    if (cyc >= LAT + 1) begin
      m  = cyc - LAT - 1;
      px = m % HT;
      py = (m / HT) % VT;
      e.vis = (px < HV) && (py < VV);
      e.hs  = !((px >= HV + HFP) && (px < HV + HFP + HSW));
      e.vs  = !((py >= VV + VFP) && (py < VV + VFP + VSW));
      if (e.vis) e.rgb = hist[(m + LAT) % HIST];
    end
    return e;
  endfunction

  task automatic drive_small();
    logic [11:0] v;
    case (input_mode)
      1:       v = 12'hFFF;
      2:       v = (n >= LAT) ? {4'((n - LAT) % HT), 8'h00} : 12'h000;
      default: v = 12'($urandom);
    endcase
    {s_r, s_g, s_b} = v;
    hist[n % HIST]  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    drive_small();
  endtask

  task automatic release_small();
    s_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_reset = 1'b0;
    n = 0;
    drive_small();
  endtask

  task automatic test_reset();
    out_t got;
    req_t r;
    input_mode = 0;
    s_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {s_vga_r, s_vga_g, s_vga_b, s_hs, s_vs, s_vis};
    checks++;
    if (got !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", got, {12'h000, 3'b110});
    end
    checks++;
    if ({s_req_x, s_req_y, s_frame_count} !== 9'h000) begin
      errors++;
      $display("[TB] FAIL reset_counters: got %h expected 000", {s_req_x, s_req_y, s_frame_count});
    end
    s_reset = 1'b0;
    n = 0;
    drive_small();
    r = {s_req_valid, s_req_x, s_req_y, s_line_start, s_frame_start, s_frame_count};
    checks++;
    if (r !== {1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL first_request: got %h expected %h", r, {1'b1, 4'd0, 3'd0, 4'b1100});
    end
    while (n < LAT + 1) begin
      got = {s_vga_r, s_vga_g, s_vga_b, s_hs, s_vs, s_vis};
      checks++;
      if (got !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL idle_after_release n=%0d: got %h expected %h", n, got, {12'h000, 3'b110});
      end
      tick();
    end
    checks++;
    if (s_vis !== 1'b1 || {s_vga_r, s_vga_g, s_vga_b} !== hist[LAT]) begin
      errors++;
      $display("[TB] FAIL first_visible: got vis=%b rgb=%h expected vis=1 rgb=%h",
               s_vis, {s_vga_r, s_vga_g, s_vga_b}, hist[LAT]);
    end
  endtask

  task automatic test_pixel_pipeline(input int mode, input int cycles);
    req_t r, er;
    out_t got, eo;
    input_mode = mode;
    release_small();
    for (int i = 0; i < cycles; i++) begin
      r  = {s_req_valid, s_req_x, s_req_y, s_line_start, s_frame_start, s_frame_count};
      er = model_req(n);
      checks++;
      if (r !== er) begin
        errors++;
        $display("[TB] FAIL request_stage n=%0d: got %h expected %h", n, r, er);
      end
      got = {s_vga_r, s_vga_g, s_vga_b, s_hs, s_vs, s_vis};
      eo  = model_out(n);
      checks++;
      if (got !== eo) begin
        errors++;
        $display("[TB] FAIL output_stage mode=%0d n=%0d: got %h expected %h", mode, n, got, eo);
      end
      tick();
    end
  endtask

  task automatic test_echo_source();
    int m, mx, my;
    logic [3:0] exp_r;
    input_mode = 2;
    release_small();
    while (n < FRAME + LAT + 20) begin
      if (n >= LAT + 1) begin
        m  = n - LAT - 1;
        mx = m % HT;
        my = (m / HT) % VT;
        exp_r = (mx < HV && my < VV) ? 4'(mx) : 4'd0;
        checks++;
        if (s_vga_r !== exp_r) begin
          errors++;
          $display("[TB] FAIL echo_red n=%0d: got %0d expected %0d", n, s_vga_r, exp_r);
        end
      end
      tick();
    end
  endtask

  task automatic test_sync_counts();
    int hs_low = 0, vs_low = 0, vis_cnt = 0, first_hs = -1;
    input_mode = 0;
    release_small();
    while (n < LAT + 1 + FRAME) begin
      if (n >= LAT + 1) begin
        if (s_hs === 1'b0) begin
          hs_low++;
          if (first_hs < 0) first_hs = n;
        end
        if (s_vs === 1'b0) vs_low++;
        if (s_vis === 1'b1) vis_cnt++;
      end
      tick();
    end
    checks++;
    if (hs_low !== 2 * VT) begin
      errors++;
      $display("[TB] FAIL hsync_cycles_per_frame: got %0d expected %0d", hs_low, 2 * VT);
    end
    checks++;
    if (vs_low !== HT) begin
      errors++;
      $display("[TB] FAIL vsync_cycles_per_frame: got %0d expected %0d", vs_low, HT);
    end
    checks++;
    if (first_hs !== 10 + LAT + 1) begin
      errors++;
      $display("[TB] FAIL hsync_start: got %0d expected %0d", first_hs, 10 + LAT + 1);
    end
    checks++;
    if (vis_cnt !== HV * VV) begin
      errors++;
      $display("[TB] FAIL visible_per_frame: got %0d expected %0d", vis_cnt, HV * VV);
    end
  endtask

  task automatic test_frame_boundaries();
    int line_starts = 0, frame_starts = 0, increments = 0;
    logic [1:0] prev_fc;
    input_mode = 0;
    release_small();
    prev_fc = s_frame_count;
    while (n <= 4 * FRAME) begin
      if (n < FRAME) begin
        if (s_line_start === 1'b1) line_starts++;
        if (s_frame_start === 1'b1) frame_starts++;
      end
      if (s_frame_count !== prev_fc) increments++;
      prev_fc = s_frame_count;
      if (n == 3 * FRAME - 1 || n == 3 * FRAME || n == 4 * FRAME) begin
        checks++;
        if (s_frame_count !== 2'((n / FRAME) % 4)) begin
          errors++;
          $display("[TB] FAIL frame_count n=%0d: got %0d expected %0d", n, s_frame_count, (n / FRAME) % 4);
        end
      end
      tick();
    end
    checks++;
    if (line_starts !== VT) begin
      errors++;
      $display("[TB] FAIL line_starts_per_frame: got %0d expected %0d", line_starts, VT);
    end
    checks++;
    if (frame_starts !== 1) begin
      errors++;
      $display("[TB] FAIL frame_starts_per_frame: got %0d expected 1", frame_starts);
    end
    checks++;
    if (increments !== 4) begin
      errors++;
      $display("[TB] FAIL frame_count_changes: got %0d expected 4", increments);
    end
  endtask

  task automatic test_mid_frame_reset();
    input_mode = 0;
    release_small();
    while (n < 2 * HT + 5) tick();
    checks++;
    if (s_req_x !== 4'd5 || s_req_y !== 3'd2) begin
      errors++;
      $display("[TB] FAIL reset_point: got (%0d,%0d) expected (5,2)", s_req_x, s_req_y);
    end
    s_reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({s_vga_r, s_vga_g, s_vga_b, s_hs, s_vs, s_vis} !== {12'h000, 3'b110}) begin
      errors++;
      $display("[TB] FAIL mid_reset_idle: got %h expected %h",
               {s_vga_r, s_vga_g, s_vga_b, s_hs, s_vs, s_vis}, {12'h000, 3'b110});
    end
    s_reset = 1'b0;
    n = 0;
    drive_small();
    for (int i = 0; i < 2 * FRAME; i++) begin
      checks++;
      if ({s_req_valid, s_req_x, s_req_y, s_line_start, s_frame_start, s_frame_count} !== model_req(n)) begin
        errors++;
        $display("[TB] FAIL post_reset_request n=%0d: got %h expected %h", n,
                 {s_req_valid, s_req_x, s_req_y, s_line_start, s_frame_start, s_frame_count}, model_req(n));
      end
      checks++;
      if ({s_vga_r, s_vga_g, s_vga_b, s_hs, s_vs, s_vis} !== model_out(n)) begin
        errors++;
        $display("[TB] FAIL post_reset_output n=%0d: got %h expected %h", n,
                 {s_vga_r, s_vga_g, s_vga_b, s_hs, s_vs, s_vis}, model_out(n));
      end
      tick();
    end
  endtask

  task automatic test_default_mode();
    int dn = 0, hs_low = 0, vis_cnt = 0, first_hs = -1, blank_rgb = 0, vs_low = 0;
    d_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d_reset = 1'b0;
    while (dn <= 3 * 800) begin
      {d_r, d_g, d_b} = 12'($urandom);
      if (dn >= 3 && dn < 803) begin
        if (d_hs === 1'b0) begin
          hs_low++;
          if (first_hs < 0) first_hs = dn;
        end
        if (d_vis === 1'b1) vis_cnt++;
      end
      if (d_vs === 1'b0) vs_low++;
      if (d_vis !== 1'b1 && {d_vga_r, d_vga_g, d_vga_b} !== 12'h000) blank_rgb++;
      if (dn == 800 || dn == 1600) begin
        checks++;
        if (d_req_x !== 10'd0 || d_req_y !== 10'(dn / 800) || d_line_start !== 1'b1) begin
          errors++;
          $display("[TB] FAIL default_line_wrap dn=%0d: got x=%0d y=%0d ls=%b expected x=0 y=%0d ls=1",
                   dn, d_req_x, d_req_y, d_line_start, dn / 800);
        end
      end
      @(posedge clk);
      #1;
      dn++;
    end
    checks++;
    if (hs_low !== 96) begin
      errors++;
      $display("[TB] FAIL default_hsync_width: got %0d expected 96", hs_low);
    end
    checks++;
    if (first_hs !== 656 + LAT + 1) begin
      errors++;
      $display("[TB] FAIL default_hsync_start: got %0d expected %0d", first_hs, 656 + LAT + 1);
    end
    checks++;
    if (vis_cnt !== 640) begin
      errors++;
      $display("[TB] FAIL default_visible_per_line: got %0d expected 640", vis_cnt);
    end
    checks++;
    if (blank_rgb !== 0 || vs_low !== 0 || d_frame_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL default_blanking: got blank_rgb=%0d vs_low=%0d fc=%0d expected 0 0 0",
               blank_rgb, vs_low, d_frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_pixel_pipeline(0, 4 * FRAME + 10);
    test_pixel_pipeline(1, FRAME + 10);
    test_echo_source();
    test_sync_counts();
    test_frame_boundaries();
    test_mid_frame_reset();
    test_default_mode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
